id_stage_q: RTL and testbench

- Decoupled, parametrised instruction-decode stage for the 5-stage RV32 pipeline.
- Buffers IF/ID entries in a DEPTH-entry instruction queue, so fetch keeps running while EX back-pressures.
- Decodes the queue head, reads the register file with WB bypass, and presents an ID/EX bundle under a valid/ready handshake.
- Adds an RV32E mode (NUM_REGS=16) and illegal-instruction detection.

---
 rtl/riscvibe_pkg.sv | 72 +++++++
 rtl/control_unit.sv | 102 ++++++++++
 rtl/id_stage_q_instr_queue.sv | 60 ++++++
 rtl/immediate_gen.sv | 31 +++
 rtl/register_file.sv | 40 ++++
 rtl/id_stage_q.sv | 161 ++++++++++++++++
 tb/tb_id_stage_q.sv | 219 +++++++++++++++++++++
 7 files changed

// File: rtl/riscvibe_pkg.sv
// Shared RV32 pipeline types for the decode stage.
// Holds the IF/ID and ID/EX bundle layouts, the decoded-control enums,
// the base opcode constants, the bubble bundle NOP_ID_EX and the
// base-opcode legality helper is_rv32i_opcode().
package riscvibe_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [3:0] {
    BRANCH_NONE, BRANCH_BEQ, BRANCH_BNE, BRANCH_BLT, BRANCH_BGE,
    BRANCH_BLTU, BRANCH_BGEU, BRANCH_JAL, BRANCH_JALR
  } branch_type_t;

  typedef enum logic [1:0] {
    WB_SRC_ALU, WB_SRC_MEM, WB_SRC_PC4
  } reg_wr_src_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] instruction;
    logic        valid;
  } if_id_reg_t;

  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  pc_plus_4;
    logic [31:0]  rs1_data;
    logic [31:0]  rs2_data;
    logic [31:0]  immediate;
    logic [4:0]   rs1_addr;
    logic [4:0]   rs2_addr;
    logic [4:0]   rd_addr;
    logic [2:0]   funct3;
    alu_op_t      alu_op;
    logic         alu_src_a_pc;
    logic         alu_src_b_imm;
    branch_type_t branch_type;
    reg_wr_src_t  reg_wr_src;
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
    logic         valid;
  } id_ex_reg_t;

  // All-zero bundle: no writes, no memory access, BRANCH_NONE, ALU_ADD.
  localparam id_ex_reg_t NOP_ID_EX = '0;

  function automatic logic is_rv32i_opcode(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit: RV32I main decoder.
// Inputs: opcode, funct3, funct7 bit 5 (instruction[30]).
// Outputs: ALU op/operand selects, branch type, write-back source,
// reg/mem enables, which register fields the format uses, and whether
// the opcode is an RV32I base opcode.
module control_unit
  import riscvibe_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic         funct7_5,
  output alu_op_t      alu_op,
  output logic         alu_src_a_pc,
  output logic         alu_src_b_imm,
  output branch_type_t branch_type,
  output reg_wr_src_t  reg_wr_src,
  output logic         reg_write,
  output logic         mem_read,
  output logic         mem_write,
  output logic         uses_rd,
  output logic         uses_rs1,
  output logic         uses_rs2,
  output logic         opcode_legal
);

  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    alu_op        = ALU_ADD;
    alu_src_a_pc  = 1'b0;
    alu_src_b_imm = 1'b0;
    branch_type   = BRANCH_NONE;
    reg_wr_src    = WB_SRC_ALU;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    uses_rd       = 1'b0;
    uses_rs1      = 1'b0;
    uses_rs2      = 1'b0;
    opcode_legal  = is_rv32i_opcode(opcode);
    case (opcode)
      OPC_LUI: begin
        alu_op = ALU_PASS_B; alu_src_b_imm = 1'b1; reg_write = 1'b1; uses_rd = 1'b1;
      end
      OPC_AUIPC: begin
        alu_src_a_pc = 1'b1; alu_src_b_imm = 1'b1; reg_write = 1'b1; uses_rd = 1'b1;
      end
      OPC_JAL: begin
        branch_type = BRANCH_JAL; reg_wr_src = WB_SRC_PC4; reg_write = 1'b1; uses_rd = 1'b1;
      end
      OPC_JALR: begin
        branch_type = BRANCH_JALR; reg_wr_src = WB_SRC_PC4; reg_write = 1'b1;
        alu_src_b_imm = 1'b1; uses_rd = 1'b1; uses_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        alu_op = ALU_SUB; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        case (funct3)
          3'b000:  branch_type = BRANCH_BEQ;
          3'b001:  branch_type = BRANCH_BNE;
          3'b100:  branch_type = BRANCH_BLT;
          3'b101:  branch_type = BRANCH_BGE;
          3'b110:  branch_type = BRANCH_BLTU;
          3'b111:  branch_type = BRANCH_BGEU;
          default: branch_type = BRANCH_NONE;
        endcase
      end
      OPC_LOAD: begin
        mem_read = 1'b1; reg_wr_src = WB_SRC_MEM; reg_write = 1'b1;
        alu_src_b_imm = 1'b1; uses_rd = 1'b1; uses_rs1 = 1'b1;
      end
      OPC_STORE: begin
        mem_write = 1'b1; alu_src_b_imm = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only SRAI uses bit 30 as an opcode extension; elsewhere it is immediate.
        alu_op = alu_from_f3(funct3, (funct3 == 3'b101) && funct7_5);
        alu_src_b_imm = 1'b1; reg_write = 1'b1; uses_rd = 1'b1; uses_rs1 = 1'b1;
      end
      OPC_OP: begin
        alu_op = alu_from_f3(funct3, funct7_5);
        reg_write = 1'b1; uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        // I-type layout: rd and rs1 fields are architecturally present.
        uses_rd = 1'b1; uses_rs1 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage_q_instr_queue.sv
// instr_queue: DEPTH-entry circular FIFO of IF/ID entries.
// Ports: clk, rst_n (async active-low), flush (clears pointers and count
// next cycle, drops same-cycle push/pop), push/wr_data, pop/rd_data (head),
// full, empty, count (occupancy).
// The caller only asserts push when !full and pop when !empty.
module instr_queue
  import riscvibe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  if_id_reg_t                   wr_data,
  output if_id_reg_t                   rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  if_id_reg_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Entry storage is data only and is not reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/immediate_gen.sv
// immediate_gen: sign-extended immediate for every RV32I format.
// Input: full instruction word. Output: 32-bit immediate (0 for R-type).
module immediate_gen
  import riscvibe_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [31:0] immediate
);

  logic [31:0] i;
  assign i = instruction;

  always_comb begin
    immediate = '0;
    case (i[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM:
        immediate = {{20{i[31]}}, i[31:20]};
      OPC_STORE:
        immediate = {{20{i[31]}}, i[31:25], i[11:7]};
      OPC_BRANCH:
        immediate = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        immediate = {i[31:12], 12'b0};
      OPC_JAL:
        immediate = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:
        immediate = '0;
    endcase
  end

endmodule

// File: rtl/register_file.sv
// register_file: NUM_REGS x 32 architectural registers, two async reads,
// one sync write. Cleared on reset. Writes to x0 or to addresses beyond
// NUM_REGS are dropped; reads beyond NUM_REGS return 0.
// Ports: clk, rst_n, rs1_addr/rs1_data, rs2_addr/rs2_data,
// rd_addr/rd_data/reg_write.
module register_file #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  input  logic        reg_write
);

  localparam int         AW = $clog2(NUM_REGS);
  localparam logic [5:0] NR = 6'(NUM_REGS);

  logic [31:0] regs [NUM_REGS];

  function automatic logic in_range(input logic [4:0] a);
    return ({1'b0, a} < NR);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (reg_write && (rd_addr != 5'd0) && in_range(rd_addr)) begin
      regs[rd_addr[AW-1:0]] <= rd_data;
    end
  end

  assign rs1_data = in_range(rs1_addr) ? regs[rs1_addr[AW-1:0]] : '0;
  assign rs2_data = in_range(rs2_addr) ? regs[rs2_addr[AW-1:0]] : '0;

endmodule

// File: rtl/id_stage_q.sv
// id_stage_q: decoupled RV32 instruction-decode stage.
// IF entries are buffered in a DEPTH-entry queue; the queue head is decoded
// combinationally, its operands are read from the register file with WB
// bypass, and the result is offered to EX under id_ex_valid/ex_ready.
// Ports: clk, rst_n (async active-low), flush, stall,
//   if_valid/if_ready/if_id_in   fetch side (if_ready = !full),
//   wb_rd_addr/wb_rd_data/wb_reg_write   write-back port,
//   ex_ready/id_ex_valid/id_ex_out       execute side,
//   illegal_instr (head is illegal), q_count (occupancy).
module id_stage_q
  import riscvibe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        stall,
  input  logic                        if_valid,
  output logic                        if_ready,
  input  if_id_reg_t                  if_id_in,
  input  logic [4:0]                  wb_rd_addr,
  input  logic [XLEN-1:0]             wb_rd_data,
  input  logic                        wb_reg_write,
  input  logic                        ex_ready,
  output logic                        id_ex_valid,
  output id_ex_reg_t                  id_ex_out,
  output logic                        illegal_instr,
  output logic [$clog2(DEPTH+1)-1:0]  q_count
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("id_stage_q: XLEN must be 32");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("id_stage_q: DEPTH must be a power of two >= 2");
  end
  if (NUM_REGS != 32 && NUM_REGS != 16) begin : g_bad_nregs
    $error("id_stage_q: NUM_REGS must be 32 or 16");
  end

  logic         full, empty, push, pop;
  if_id_reg_t   head;
  logic [31:0]  instr;
  logic [4:0]   rs1_addr, rs2_addr, rd_addr;
  logic [31:0]  rf_rs1, rf_rs2, rs1_val, rs2_val, imm;
  logic         illegal_core, rv32e_bad;

  alu_op_t      alu_op;
  branch_type_t branch_type;
  reg_wr_src_t  reg_wr_src;
  logic         alu_src_a_pc, alu_src_b_imm, reg_write, mem_read, mem_write;
  logic         uses_rd, uses_rs1, uses_rs2, opcode_legal;

  assign if_ready = !full;
  assign push     = if_valid && !full && if_id_in.valid && !flush;
  // A non-empty, non-stalled, non-flushed head is either issuable or illegal,
  // and both leave the queue on ex_ready.
  assign pop      = ex_ready && !empty && !stall && !flush;

  instr_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (if_id_in),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (q_count)
  );

  assign instr    = head.instruction;
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign rd_addr  = instr[11:7];

  control_unit u_ctrl (
    .opcode        (instr[6:0]),
    .funct3        (instr[14:12]),
    .funct7_5      (instr[30]),
    .alu_op        (alu_op),
    .alu_src_a_pc  (alu_src_a_pc),
    .alu_src_b_imm (alu_src_b_imm),
    .branch_type   (branch_type),
    .reg_wr_src    (reg_wr_src),
    .reg_write     (reg_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .uses_rd       (uses_rd),
    .uses_rs1      (uses_rs1),
    .uses_rs2      (uses_rs2),
    .opcode_legal  (opcode_legal)
  );

  immediate_gen u_imm (
    .instruction (instr),
    .immediate   (imm)
  );

  register_file #(.NUM_REGS(NUM_REGS)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rf_rs1),
    .rs2_data  (rf_rs2),
    .rd_addr   (wb_rd_addr),
    .rd_data   (wb_rd_data),
    .reg_write (wb_reg_write)
  );

  // Same-cycle WB forwarding so a head waiting on a producer sees its result.
  function automatic logic [31:0] read_bypass(input logic [4:0] a, input logic [31:0] rf_val,
                                              input logic we, input logic [4:0] wa,
                                              input logic [31:0] wd);
    if (a == 5'd0)            return '0;
    if (we && (wa == a))      return wd;
    return rf_val;
  endfunction

  assign rs1_val = read_bypass(rs1_addr, rf_rs1, wb_reg_write, wb_rd_addr, wb_rd_data);
  assign rs2_val = read_bypass(rs2_addr, rf_rs2, wb_reg_write, wb_rd_addr, wb_rd_data);

  // RV32E only has x0..x15: bit 4 of any field the format actually uses is illegal.
  assign rv32e_bad = (NUM_REGS == 16) &&
                     ((uses_rd && rd_addr[4]) || (uses_rs1 && rs1_addr[4]) ||
                      (uses_rs2 && rs2_addr[4]));

  assign illegal_core  = (instr[1:0] != 2'b11) || !opcode_legal || rv32e_bad;
  assign illegal_instr = !empty && !flush && illegal_core;
  assign id_ex_valid   = !empty && !stall && !flush && !illegal_core;

  always_comb begin
    id_ex_out = NOP_ID_EX;
    if (id_ex_valid) begin
      id_ex_out.pc            = head.pc;
      id_ex_out.pc_plus_4     = head.pc_plus_4;
      id_ex_out.rs1_data      = rs1_val;
      id_ex_out.rs2_data      = rs2_val;
      id_ex_out.immediate     = imm;
      id_ex_out.rs1_addr      = rs1_addr;
      id_ex_out.rs2_addr      = rs2_addr;
      id_ex_out.rd_addr       = rd_addr;
      id_ex_out.funct3        = instr[14:12];
      id_ex_out.alu_op        = alu_op;
      id_ex_out.alu_src_a_pc  = alu_src_a_pc;
      id_ex_out.alu_src_b_imm = alu_src_b_imm;
      id_ex_out.branch_type   = branch_type;
      id_ex_out.reg_wr_src    = reg_wr_src;
      id_ex_out.reg_write     = reg_write;
      id_ex_out.mem_read      = mem_read;
      id_ex_out.mem_write     = mem_write;
      id_ex_out.valid         = head.valid;
    end
  end

endmodule

// File: tb/tb_id_stage_q.sv
// Directed bench for id_stage_q: an RV32I instance and an RV32E instance
// share every input; each section checks hand-computed outputs.
module tb_id_stage_q;
  import riscvibe_pkg::*;

  localparam logic [31:0] I_ADDI_X1_5 = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADDI_X2_7 = 32'h0070_0113; // addi x2,x0,7
  localparam logic [31:0] I_ADDI_X4_9 = 32'h0090_0213; // addi x4,x0,9
  localparam logic [31:0] I_ADD_X3    = 32'h0020_81B3; // add  x3,x1,x2
  localparam logic [31:0] I_ADD_X17   = 32'h0020_88B3; // add  x17,x1,x2

  logic        clk, rst_n, flush, stall, if_valid, wb_reg_write, ex_ready;
  if_id_reg_t  if_id_in;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;

  logic        if_ready, id_ex_valid, illegal_instr;
  id_ex_reg_t  id_ex_out;
  logic [1:0]  q_count;
  logic        if_ready_e, id_ex_valid_e, illegal_instr_e;
  id_ex_reg_t  id_ex_out_e;
  logic [1:0]  q_count_e;

  int n_vec, n_miss;

  id_stage_q #(.XLEN(32), .DEPTH(2), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .if_valid(if_valid), .if_ready(if_ready), .if_id_in(if_id_in),
    .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data), .wb_reg_write(wb_reg_write),
    .ex_ready(ex_ready), .id_ex_valid(id_ex_valid), .id_ex_out(id_ex_out),
    .illegal_instr(illegal_instr), .q_count(q_count)
  );

  id_stage_q #(.XLEN(32), .DEPTH(2), .NUM_REGS(16)) dut_e (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .if_valid(if_valid), .if_ready(if_ready_e), .if_id_in(if_id_in),
    .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data), .wb_reg_write(wb_reg_write),
    .ex_ready(ex_ready), .id_ex_valid(id_ex_valid_e), .id_ex_out(id_ex_out_e),
    .illegal_instr(illegal_instr_e), .q_count(q_count_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] instr);
    if_valid             = 1'b1;
    if_id_in.pc          = pc;
    if_id_in.pc_plus_4   = pc + 32'd4;
    if_id_in.instruction = instr;
    if_id_in.valid       = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0; ex_ready = 1'b0;
    wb_reg_write = 1'b0; wb_rd_addr = '0; wb_rd_data = '0;
    if_valid = 1'b0; if_id_in = '0;

    // reset with IF offering an entry
    present(32'h0, I_ADDI_X1_5);
    #2;
    expect_eq("rst_if_ready", 64'(if_ready), 64'd1);
    expect_eq("rst_valid",    64'(id_ex_valid), 64'd0);
    expect_eq("rst_count",    64'(q_count), 64'd0);
    expect_eq("rst_regwrite", 64'(id_ex_out.reg_write), 64'd0);
    cyc; cyc;
    expect_eq("rst_count_held", 64'(q_count), 64'd0);
    rst_n = 1'b1;
    cyc;
    if_valid = 1'b0;
    #1;
    expect_eq("addi_valid", 64'(id_ex_valid), 64'd1);
    expect_eq("addi_imm",   64'(id_ex_out.immediate), 64'd5);
    expect_eq("addi_rd",    64'(id_ex_out.rd_addr), 64'd1);
    expect_eq("addi_count", 64'(q_count), 64'd1);
    expect_eq("addi_regwr", 64'(id_ex_out.reg_write), 64'd1);
    ex_ready = 1'b1;
    cyc;
    expect_eq("addi_popped", 64'(q_count), 64'd0);
    expect_eq("empty_valid", 64'(id_ex_valid), 64'd0);
    ex_ready = 1'b0;

    // fill under back-pressure, then drain in order
    present(32'h10, I_ADDI_X2_7); cyc;
    present(32'h14, I_ADDI_X4_9); cyc;
    present(32'h18, I_ADD_X3);
    #1;
    expect_eq("full_count",    64'(q_count), 64'd2);
    expect_eq("full_if_ready", 64'(if_ready), 64'd0);
    expect_eq("full_head_pc",  64'(id_ex_out.pc), 64'h10);
    expect_eq("full_head_imm", 64'(id_ex_out.immediate), 64'd7);
    cyc;
    expect_eq("held_count", 64'(q_count), 64'd2);
    ex_ready = 1'b1;
    #1;
    expect_eq("drain_valid", 64'(id_ex_valid), 64'd1);
    cyc;
    expect_eq("pop1_count",    64'(q_count), 64'd1);
    expect_eq("pop1_pc",       64'(id_ex_out.pc), 64'h14);
    expect_eq("pop1_if_ready", 64'(if_ready), 64'd1);
    cyc;
    if_valid = 1'b0;
    #1;
    expect_eq("pushpop_count", 64'(q_count), 64'd1);
    expect_eq("third_pc",      64'(id_ex_out.pc), 64'h18);
    cyc;
    expect_eq("drained", 64'(q_count), 64'd0);

    // WB bypass on a held head
    ex_ready = 1'b0;
    present(32'h20, I_ADD_X3); cyc;
    if_valid = 1'b0;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd1; wb_rd_data = 32'hDEAD_BEEF;
    #1;
    expect_eq("byp_rs1", 64'(id_ex_out.rs1_data), 64'hDEAD_BEEF);
    expect_eq("byp_rs2", 64'(id_ex_out.rs2_data), 64'h0);
    cyc;
    wb_reg_write = 1'b0; wb_rd_data = '0;
    #1;
    expect_eq("rf_rs1_persist", 64'(id_ex_out.rs1_data), 64'hDEAD_BEEF);
    expect_eq("held_one",       64'(q_count), 64'd1);

    // flush while full, with IF offering and WB writing x0
    present(32'h24, I_ADDI_X2_7); cyc;
    present(32'h28, I_ADDI_X4_9);
    flush = 1'b1;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd0; wb_rd_data = 32'h1234_5678;
    #1;
    expect_eq("flush_bubble",  64'(id_ex_valid), 64'd0);
    expect_eq("flush_regwr",   64'(id_ex_out.reg_write), 64'd0);
    expect_eq("flush_illegal", 64'(illegal_instr), 64'd0);
    cyc;
    flush = 1'b0; if_valid = 1'b0; wb_reg_write = 1'b0;
    #1;
    expect_eq("post_flush_count", 64'(q_count), 64'd0);
    expect_eq("post_flush_valid", 64'(id_ex_valid), 64'd0);
    expect_eq("post_flush_ready", 64'(if_ready), 64'd1);
    // flush with a push into a non-full queue drops that push
    present(32'h30, I_ADDI_X1_5); cyc;
    present(32'h34, I_ADDI_X2_7);
    flush = 1'b1;
    cyc;
    flush = 1'b0; if_valid = 1'b0;
    #1;
    expect_eq("flush_drops_push", 64'(q_count), 64'd0);
    present(32'h40, I_ADDI_X1_5); cyc;
    if_valid = 1'b0;
    #1;
    expect_eq("x0_reads_zero", 64'(id_ex_out.rs1_data), 64'h0);
    expect_eq("refill_pc",     64'(id_ex_out.pc), 64'h40);
    ex_ready = 1'b1; cyc; ex_ready = 1'b0;

    // stall alone blocks issue and pop
    present(32'h50, I_ADDI_X4_9); cyc;
    if_valid = 1'b0; stall = 1'b1; ex_ready = 1'b1;
    #1;
    expect_eq("stall_bubble", 64'(id_ex_valid), 64'd0);
    expect_eq("stall_regwr",  64'(id_ex_out.reg_write), 64'd0);
    cyc;
    expect_eq("stall_no_pop", 64'(q_count), 64'd1);

    // stall + flush together
    flush = 1'b1;
    #1;
    expect_eq("sf_valid",  64'(id_ex_valid), 64'd0);
    expect_eq("sf_branch", 64'(id_ex_out.branch_type), 64'(BRANCH_NONE));
    expect_eq("sf_regwr",  64'(id_ex_out.reg_write), 64'd0);
    cyc;
    flush = 1'b0; stall = 1'b0; ex_ready = 1'b0;
    #1;
    expect_eq("sf_cleared", 64'(q_count), 64'd0);

    // RV32E: x17 destination is illegal only in the 16-register instance
    present(32'h60, I_ADD_X17); cyc;
    if_valid = 1'b0;
    #1;
    expect_eq("e_illegal",     64'(illegal_instr_e), 64'd1);
    expect_eq("e_valid",       64'(id_ex_valid_e), 64'd0);
    expect_eq("e_regwr",       64'(id_ex_out_e.reg_write), 64'd0);
    expect_eq("i_legal",       64'(illegal_instr), 64'd0);
    expect_eq("i_valid",       64'(id_ex_valid), 64'd1);
    expect_eq("i_rd17",        64'(id_ex_out.rd_addr), 64'd17);
    expect_eq("i_rs1_x1",      64'(id_ex_out.rs1_data), 64'hDEAD_BEEF);
    ex_ready = 1'b1; cyc;
    expect_eq("e_illegal_pop", 64'(q_count_e), 64'd0);
    expect_eq("i_pop",         64'(q_count), 64'd0);
    ex_ready = 1'b0;

    // all-zero word is illegal in both modes
    present(32'h64, 32'h0000_0000); cyc;
    if_valid = 1'b0;
    #1;
    expect_eq("zero_illegal_i", 64'(illegal_instr), 64'd1);
    expect_eq("zero_illegal_e", 64'(illegal_instr_e), 64'd1);
    expect_eq("zero_valid_i",   64'(id_ex_valid), 64'd0);
    expect_eq("zero_valid_e",   64'(id_ex_valid_e), 64'd0);
    ex_ready = 1'b1; cyc;
    expect_eq("zero_pop_i", 64'(q_count), 64'd0);
    expect_eq("zero_pop_e", 64'(q_count_e), 64'd0);
    ex_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
